// File: rtl/dm_s2mm_scheduler.sv
// Scheduler for a data-mover S2MM channel: walks a ring of equally sized blocks.
// It issues one write command at a time and advances on each good status.
module dm_s2mm_scheduler #(
    parameter int MM_ADDR_WIDTH = 32,
    parameter int NUM_WIDTH     = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic                       stop,
    input  logic [MM_ADDR_WIDTH-1:0]   cfg_base_addr,
    input  logic [22:0]                cfg_block_bytes,
    input  logic [NUM_WIDTH-1:0]       cfg_block_num,
    input  logic                       cfg_continuous,
    output logic                       cmd_tvalid,
    input  logic                       cmd_tready,
    output logic [MM_ADDR_WIDTH+39:0]  cmd_tdata,
    input  logic                       sts_tvalid,
    output logic                       sts_tready,
    input  logic [7:0]                 sts_tdata,
    output logic                       busy,
    output logic                       blk_done,
    output logic [31:0]                blk_cnt,
    output logic [NUM_WIDTH-1:0]       wr_idx,
    output logic                       err,
    output logic [3:0]                 err_code
);

    typedef enum logic [1:0] {IDLE, CMD, WAIT_STS, HALT} state_t;

    state_t                     state, state_nxt;
    logic [MM_ADDR_WIDTH-1:0]   base, base_nxt, addr, addr_nxt;
    logic [22:0]                btt, btt_nxt;
    logic [NUM_WIDTH-1:0]       num, num_nxt, idx, idx_nxt, wr_idx_nxt, num_m1;
    logic                       cont, cont_nxt;
    logic                       cmd_tvalid_nxt, sts_tready_nxt, blk_done_nxt;
    logic [31:0]                blk_cnt_nxt;
    logic                       err_nxt, stop_pend, stop_pend_nxt;
    logic [3:0]                 err_code_nxt;
    logic                       sts_good, last_blk;

    // Assertion is immediate; release is retimed to clk through two flops.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rst_sync <= 2'b00;
        else       rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    assign busy      = (state != IDLE);
    assign num_m1    = num - NUM_WIDTH'(1);
    assign last_blk  = (idx == num_m1);
    assign sts_good  = sts_tdata[7] && (sts_tdata[6:4] == 3'b000) && (sts_tdata[3:0] == idx[3:0]);

    // Command word is forced to zero whenever no command is being offered.
    assign cmd_tdata = cmd_tvalid ?
        {4'h0, idx[3:0], addr, 1'b0, 1'b1, 6'b000000, 1'b1, btt} : '0;

    always_comb begin
        state_nxt      = state;
        base_nxt       = base;
        btt_nxt        = btt;
        num_nxt        = num;
        cont_nxt       = cont;
        addr_nxt       = addr;
        idx_nxt        = idx;
        cmd_tvalid_nxt = cmd_tvalid;
        sts_tready_nxt = sts_tready;
        blk_done_nxt   = 1'b0;
        blk_cnt_nxt    = blk_cnt;
        wr_idx_nxt     = wr_idx;
        err_nxt        = err;
        err_code_nxt   = err_code;
        stop_pend_nxt  = stop_pend | (stop & (state != IDLE));

        case (state)
            IDLE: begin
                if (start) begin
                    base_nxt      = cfg_base_addr;
                    btt_nxt       = cfg_block_bytes;
                    num_nxt       = cfg_block_num;
                    cont_nxt      = cfg_continuous;
                    stop_pend_nxt = 1'b0;
                    if ((cfg_block_bytes == '0) || (cfg_block_num == '0)) begin
                        err_nxt      = 1'b1;
                        err_code_nxt = 4'h1;
                        state_nxt    = HALT;
                    end else begin
                        addr_nxt       = cfg_base_addr;
                        idx_nxt        = '0;
                        blk_cnt_nxt    = '0;
                        wr_idx_nxt     = '0;
                        err_nxt        = 1'b0;
                        err_code_nxt   = 4'h0;
                        cmd_tvalid_nxt = 1'b1;
                        state_nxt      = CMD;
                    end
                end
            end
            CMD: begin
                if (cmd_tready) begin
                    cmd_tvalid_nxt = 1'b0;
                    sts_tready_nxt = 1'b1;
                    state_nxt      = WAIT_STS;
                end
            end
            WAIT_STS: begin
                if (sts_tvalid) begin
                    sts_tready_nxt = 1'b0;
                    if (sts_good) begin
                        blk_done_nxt = 1'b1;
                        blk_cnt_nxt  = blk_cnt + 32'd1;
                        wr_idx_nxt   = idx;
                        if (stop_pend_nxt || (!cont && last_blk)) begin
                            state_nxt = HALT;
                        end else if (last_blk) begin
                            idx_nxt        = '0;
                            addr_nxt       = base;
                            cmd_tvalid_nxt = 1'b1;
                            state_nxt      = CMD;
                        end else begin
                            idx_nxt        = idx + NUM_WIDTH'(1);
                            addr_nxt       = addr + MM_ADDR_WIDTH'(btt);
                            cmd_tvalid_nxt = 1'b1;
                            state_nxt      = CMD;
                        end
                    end else begin
                        err_nxt      = 1'b1;
                        err_code_nxt = (sts_tdata[6:4] != 3'b000) ? 4'h2 : 4'h3;
                        state_nxt    = HALT;
                    end
                end
            end
            HALT: begin
                stop_pend_nxt = 1'b0;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state      <= IDLE;
            base       <= '0;
            btt        <= '0;
            num        <= '0;
            cont       <= 1'b0;
            addr       <= '0;
            idx        <= '0;
            cmd_tvalid <= 1'b0;
            sts_tready <= 1'b0;
            blk_done   <= 1'b0;
            blk_cnt    <= '0;
            wr_idx     <= '0;
            err        <= 1'b0;
            err_code   <= 4'h0;
            stop_pend  <= 1'b0;
        end else begin
            state      <= state_nxt;
            base       <= base_nxt;
            btt        <= btt_nxt;
            num        <= num_nxt;
            cont       <= cont_nxt;
            addr       <= addr_nxt;
            idx        <= idx_nxt;
            cmd_tvalid <= cmd_tvalid_nxt;
            sts_tready <= sts_tready_nxt;
            blk_done   <= blk_done_nxt;
            blk_cnt    <= blk_cnt_nxt;
            wr_idx     <= wr_idx_nxt;
            err        <= err_nxt;
            err_code   <= err_code_nxt;
            stop_pend  <= stop_pend_nxt;
        end
    end

endmodule
